// File: rtl/enc_collect_seq_pkg.sv
// enc_collect_seq_pkg
// Shared constants for the encoder collection sequencer:
//   - OFF_BUF_ENC_* type-select codes driven onto buf_data_type
//   - mapping from type_mask bit index to type code
//   - FSM state encoding and FIFO word layout
//   - next-set-bit helpers used to walk the type mask
package enc_collect_seq_pkg;

    localparam int NUM_TYPES = 5;
    localparam int DATA_W    = 32;
    localparam int TAG_W     = 8;

    // Type codes; 0 is left unused so an idle mux select reads as "none".
    localparam logic [3:0] OFF_BUF_ENC_DATA = 4'd1;
    localparam logic [3:0] OFF_BUF_ENC_PER  = 4'd2;
    localparam logic [3:0] OFF_BUF_ENC_QTR1 = 4'd3;
    localparam logic [3:0] OFF_BUF_ENC_QTR5 = 4'd4;
    localparam logic [3:0] OFF_BUF_ENC_RUN  = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_WAIT = 2'd2,
        ST_CAP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;   // {chan[3:0], type[3:0]}
    } fifo_word_t;

    function automatic logic [3:0] type_code(input logic [2:0] idx);
        case (idx)
            3'd0:    return OFF_BUF_ENC_DATA;
            3'd1:    return OFF_BUF_ENC_PER;
            3'd2:    return OFF_BUF_ENC_QTR1;
            3'd3:    return OFF_BUF_ENC_QTR5;
            default: return OFF_BUF_ENC_RUN;
        endcase
    endfunction

    function automatic logic [2:0] lowest_bit(input logic [4:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = NUM_TYPES - 1; i >= 0; i--)
            if (m[i]) r = 3'(i);
        return r;
    endfunction

    // {found, index} of the lowest set bit strictly above cur.
    function automatic logic [3:0] next_bit(input logic [4:0] m, input logic [2:0] cur);
        logic [3:0] r;
        r = 4'd0;
        for (int i = NUM_TYPES - 1; i >= 0; i--)
            if (m[i] && (i > int'(cur))) r = {1'b1, 3'(i)};
        return r;
    endfunction

endpackage

// File: rtl/enc_collect_seq_if.sv
// enc_collect_seq_if
// Output stream from the collection FIFO to the data-buffer writer.
//   out_data  : FIFO head word
//   out_tag   : FIFO head tag {chan, type}
//   out_valid : FIFO non-empty
//   out_ready : consumer pops the head when out_valid & out_ready
interface enc_collect_seq_if;
    import enc_collect_seq_pkg::*;

    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              out_valid;
    logic              out_ready;

    modport master (output out_data, out_tag, out_valid, input  out_ready);
    modport slave  (input  out_data, out_tag, out_valid, output out_ready);
endinterface

// File: rtl/enc_collect_seq_fifo.sv
// enc_collect_fifo
// Synchronous FIFO, 40-bit words, 2^AW deep, with a registered head.
//   sysclk/reset : clock, async active-low reset
//   push_i/wdata_i : write request (ignored when full unless popping too)
//   pop_i        : read request (ignored when empty)
//   rdata_o      : registered head word, valid while !empty_o
//   full_o/empty_o : occupancy flags
module enc_collect_fifo
    import enc_collect_seq_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       push_i,
    input  fifo_word_t wdata_i,
    input  logic       pop_i,
    output fifo_word_t rdata_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int DEPTH = 1 << AW;

    fifo_word_t        mem [DEPTH];
    fifo_word_t        head_q, head_d;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              push_ok, pop_ok;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign pop_ok  = pop_i & ~empty_o;
    // A push at full is accepted only when the head leaves in the same cycle.
    assign push_ok = push_i & (~full_o | pop_ok);
    assign rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    assign cnt_d    = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    assign rdata_o  = head_q;

    // Head register tracks mem[rd_ptr] after this cycle's update; a write that
    // lands on the new head position bypasses the array.
    always_comb begin
        head_d = head_q;
        if (cnt_d != '0)
            head_d = (push_ok && (wr_ptr_q == rd_ptr_d)) ? wdata_i : mem[rd_ptr_d];
    end

    always_ff @(posedge sysclk)
        if (push_ok) mem[wr_ptr_q] <= wdata_i;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(push_ok);
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
        end
    end
endmodule

// File: rtl/enc_collect_seq.sv
// enc_collect_seq
// On each trig, walks the encoder buffer mux over channels 1..NUM_CHAN (outer)
// and every type enabled in the latched type_mask (inner), capturing each word
// with its {chan, type} tag into a FIFO. Three cycles per word: SEL, WAIT, CAP.
//   sysclk/reset      : clock, async active-low reset
//   trig/type_mask    : scan start pulse and type enables (latched at trig)
//   clr_stat          : clears ovf_count and trig_missed
//   buf_data_chan/type: registered mux selects
//   buf_collect_data  : selected encoder word
//   out               : FIFO output stream (interface)
//   busy/ovf_count/trig_missed : status
module enc_collect_seq
    import enc_collect_seq_pkg::*;
#(
    parameter int NUM_CHAN = 4,
    parameter int FIFO_AW  = 4
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 trig,
    input  logic [4:0]           type_mask,
    input  logic                 clr_stat,
    output logic [3:0]           buf_data_chan,
    output logic [3:0]           buf_data_type,
    input  logic [DATA_W-1:0]    buf_collect_data,
    enc_collect_seq_if.master    out,
    output logic                 busy,
    output logic [15:0]          ovf_count,
    output logic                 trig_missed
);
    localparam logic [3:0] LAST_CHAN = 4'(NUM_CHAN);

    state_t      state_q;
    logic [4:0]  mask_q;
    logic [3:0]  chan_q, type_q;
    logic [2:0]  tidx_q;
    logic        busy_q, missed_q;
    logic [15:0] ovf_q;
    logic [3:0]  nxt;
    logic        push, full, empty, drop;
    fifo_word_t  wdata, rdata;

    assign nxt   = next_bit(mask_q, tidx_q);
    assign push  = (state_q == ST_CAP);
    assign wdata = '{data: buf_collect_data, tag: {chan_q, type_q}};
    // out_valid is asserted whenever full, so ready alone decides the pop.
    assign drop  = push & full & ~out.out_ready;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            mask_q   <= '0;
            chan_q   <= '0;
            type_q   <= '0;
            tidx_q   <= '0;
            busy_q   <= 1'b0;
            missed_q <= 1'b0;
            ovf_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trig && (type_mask != '0)) begin
                        mask_q  <= type_mask;
                        chan_q  <= 4'd1;
                        tidx_q  <= lowest_bit(type_mask);
                        type_q  <= type_code(lowest_bit(type_mask));
                        busy_q  <= 1'b1;
                        state_q <= ST_SEL;
                    end
                end
                ST_SEL:  state_q <= ST_WAIT;
                ST_WAIT: state_q <= ST_CAP;
                ST_CAP: begin
                    if (nxt[3]) begin
                        tidx_q  <= nxt[2:0];
                        type_q  <= type_code(nxt[2:0]);
                        state_q <= ST_SEL;
                    end else if (chan_q == LAST_CHAN) begin
                        chan_q  <= '0;
                        type_q  <= '0;
                        tidx_q  <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        chan_q  <= chan_q + 4'd1;
                        tidx_q  <= lowest_bit(mask_q);
                        type_q  <= type_code(lowest_bit(mask_q));
                        state_q <= ST_SEL;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (clr_stat)                             ovf_q <= '0;
            else if (drop && (ovf_q != 16'hFFFF))      ovf_q <= ovf_q + 16'd1;

            if (clr_stat)              missed_q <= 1'b0;
            else if (trig && busy_q)   missed_q <= 1'b1;
        end
    end

    enc_collect_fifo #(.AW(FIFO_AW)) u_fifo (
        .sysclk  (sysclk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (wdata),
        .pop_i   (out.out_ready),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty)
    );

    assign out.out_data  = rdata.data;
    assign out.out_tag   = rdata.tag;
    assign out.out_valid = ~empty;

    assign buf_data_chan = chan_q;
    assign buf_data_type = type_q;
    assign busy          = busy_q;
    assign ovf_count     = ovf_q;
    assign trig_missed   = missed_q;
endmodule
